// File: rtl/pack_16.sv
// Byte-to-16-bit packer feeding the SHA3 pad stage; tuser/tlast mark the valid nibble count of the final word.
// Optional PACK16_HALF_CHK_EN adds a sticky err output for half bytes seen without tlast.
module pack_16 (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic        s_thalf,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [2:0]  m_tuser
`ifdef PACK16_HALF_CHK_EN
  ,
  output logic        err
`endif
);

  localparam logic [2:0] FULL_CODE = 3'd4;

  typedef enum logic {FILL, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic        have_q, have_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [15:0] m_tdata_q, m_tdata_d;
  logic        m_tlast_q, m_tlast_d;
  logic [2:0]  m_tuser_q, m_tuser_d;
  logic        can_load;
  logic        accept;

  assign can_load = !m_tvalid_q || m_tready;
  assign s_tready = !ARESET && (state_q == FILL) && can_load;
  assign accept   = s_tvalid && s_tready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    have_d     = have_q;
    m_tvalid_d = m_tvalid_q && !m_tready;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    if (state_q == FLUSH) begin
      // Empty final word so the pad stage always sees a terminating word
      if (can_load) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = 16'h0000;
        m_tuser_d  = 3'd3;
        m_tlast_d  = 1'b1;
        state_d    = FILL;
      end
    end else if (accept) begin
      case ({have_q, s_tlast, s_thalf})
        3'b000, 3'b001: begin
          acc_d  = s_tdata;
          have_d = 1'b1;
        end
        3'b100, 3'b101: begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {s_tdata, acc_q};
          m_tuser_d  = FULL_CODE;
          m_tlast_d  = 1'b0;
          have_d     = 1'b0;
        end
        3'b010: begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {8'h00, s_tdata};
          m_tuser_d  = 3'd1;
          m_tlast_d  = 1'b1;
        end
        3'b011: begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {12'h000, s_tdata[3:0]};
          m_tuser_d  = 3'd2;
          m_tlast_d  = 1'b1;
        end
        3'b111: begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {4'h0, s_tdata[3:0], acc_q};
          m_tuser_d  = 3'd0;
          m_tlast_d  = 1'b1;
          have_d     = 1'b0;
        end
        3'b110: begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {s_tdata, acc_q};
          m_tuser_d  = FULL_CODE;
          m_tlast_d  = 1'b0;
          have_d     = 1'b0;
          state_d    = FLUSH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= FILL;
      acc_q      <= 8'h00;
      have_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 16'h0000;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      have_q     <= have_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;

`ifdef PACK16_HALF_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (accept && s_thalf && !s_tlast);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
